// File: rtl/fifo_pkg.sv
// Shared sizing helpers and constants for the BRAM FIFO control slice.
package fifo_pkg;

   localparam int AF_AE_MARGIN = 4;

   function automatic int depth(input int addr_width);
      return 1 << addr_width;
   endfunction

   function automatic int cnt_width(input int addr_width);
      return addr_width + 1;
   endfunction

endpackage

// File: rtl/fifo_ptr_ctrl.sv
// Write/read pointers, occupancy count, accept logic and level flags for the BRAM FIFO.
module fifo_ptr_ctrl
   import fifo_pkg::*;
#(
   parameter int ADDR_WIDTH = 10,
   parameter int AF_LEVEL   = depth(ADDR_WIDTH) - AF_AE_MARGIN,
   parameter int AE_LEVEL   = AF_AE_MARGIN
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             wr,
   input  logic                             rd,
   output logic                             wr_ok,
   output logic                             rd_ok,
   output logic [ADDR_WIDTH-1:0]            w_ptr,
   output logic [ADDR_WIDTH-1:0]            r_ptr,
   output logic [cnt_width(ADDR_WIDTH)-1:0] count,
   output logic                             full,
   output logic                             empty,
   output logic                             almost_full,
   output logic                             almost_empty
);

   localparam int CW = cnt_width(ADDR_WIDTH);
   localparam logic [CW-1:0] DEPTH_CNT = CW'(depth(ADDR_WIDTH));
   localparam logic [CW-1:0] AF_CNT    = CW'(AF_LEVEL);
   localparam logic [CW-1:0] AE_CNT    = CW'(AE_LEVEL);

   logic [CW-1:0] count_next;

   // A pop frees a slot in the same cycle, so a push into a full FIFO is taken when paired with a pop.
   assign rd_ok = rd & ~empty;
   assign wr_ok = wr & (~full | rd_ok);

   always_comb begin
      count_next = count;
      case ({wr_ok, rd_ok})
         2'b10:   count_next = count + CW'(1);
         2'b01:   count_next = count - CW'(1);
         default: count_next = count;
      endcase
   end

   // Flags are registered from the next count so they stay aligned with count and never glitch.
   always_ff @(posedge clk) begin
      if (reset) begin
         w_ptr        <= '0;
         r_ptr        <= '0;
         count        <= '0;
         full         <= 1'b0;
         empty        <= 1'b1;
         almost_full  <= (AF_LEVEL == 0);
         almost_empty <= 1'b1;
      end else begin
         if (wr_ok) w_ptr <= w_ptr + ADDR_WIDTH'(1);
         if (rd_ok) r_ptr <= r_ptr + ADDR_WIDTH'(1);
         count        <= count_next;
         full         <= (count_next == DEPTH_CNT);
         empty        <= (count_next == '0);
         almost_full  <= (count_next >= AF_CNT);
         almost_empty <= (count_next <= AE_CNT);
      end
   end

endmodule

// File: rtl/fifo_bram_ctrl.sv
// BRAM FIFO control stage: drives a simple dual-port RAM and strobes r_valid one cycle after a pop.
// Define FIFO_BRAM_CTRL_ERR_EN to add sticky overflow/underflow outputs.
module fifo_bram_ctrl
   import fifo_pkg::*;
#(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 8,
   parameter int AF_LEVEL   = depth(ADDR_WIDTH) - AF_AE_MARGIN,
   parameter int AE_LEVEL   = AF_AE_MARGIN
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             wr,
   input  logic [DATA_WIDTH-1:0]            w_data,
   input  logic                             rd,
   output logic [DATA_WIDTH-1:0]            r_data,
   output logic                             r_valid,
   output logic                             full,
   output logic                             empty,
   output logic                             almost_full,
   output logic                             almost_empty,
   output logic [cnt_width(ADDR_WIDTH)-1:0] count,
   output logic                             mem_we,
   output logic [ADDR_WIDTH-1:0]            mem_addr_w,
   output logic [ADDR_WIDTH-1:0]            mem_addr_r,
   output logic [DATA_WIDTH-1:0]            mem_din,
   input  logic [DATA_WIDTH-1:0]            mem_dout
`ifdef FIFO_BRAM_CTRL_ERR_EN
   ,
   output logic                             overflow,
   output logic                             underflow
`endif
);

   logic wr_ok;
   logic rd_ok;
   logic [ADDR_WIDTH-1:0] w_ptr;
   logic [ADDR_WIDTH-1:0] r_ptr;

   fifo_ptr_ctrl #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .AF_LEVEL   (AF_LEVEL),
      .AE_LEVEL   (AE_LEVEL)
   ) u_ptr_ctrl (
      .clk          (clk),
      .reset        (reset),
      .wr           (wr),
      .rd           (rd),
      .wr_ok        (wr_ok),
      .rd_ok        (rd_ok),
      .w_ptr        (w_ptr),
      .r_ptr        (r_ptr),
      .count        (count),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty)
   );

   // The RAM reads r_ptr every cycle; r_valid marks which of those reads was actually popped.
   assign mem_we     = wr_ok;
   assign mem_addr_w = w_ptr;
   assign mem_din    = w_data;
   assign mem_addr_r = r_ptr;
   assign r_data     = mem_dout;

   always_ff @(posedge clk) begin
      if (reset) r_valid <= 1'b0;
      else       r_valid <= rd_ok;
   end

`ifdef FIFO_BRAM_CTRL_ERR_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr & full & ~rd_ok) overflow  <= 1'b1;
         if (rd & empty)         underflow <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_fifo_bram_ctrl.sv
// Directed bench for fifo_bram_ctrl with a small read-before-write dual-port RAM model attached.
module tb_fifo_bram_ctrl;

   localparam int AW = 2;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          wr;
   logic [DW-1:0] w_data;
   logic          rd;
   logic [DW-1:0] r_data;
   logic          r_valid;
   logic          full;
   logic          empty;
   logic          almost_full;
   logic          almost_empty;
   logic [AW:0]   count;
   logic          mem_we;
   logic [AW-1:0] mem_addr_w;
   logic [AW-1:0] mem_addr_r;
   logic [DW-1:0] mem_din;
   logic [DW-1:0] mem_dout;
`ifdef FIFO_BRAM_CTRL_ERR_EN
   logic          overflow;
   logic          underflow;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   fifo_bram_ctrl #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .AF_LEVEL   (3),
      .AE_LEVEL   (1)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .wr           (wr),
      .w_data       (w_data),
      .rd           (rd),
      .r_data       (r_data),
      .r_valid      (r_valid),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .count        (count),
      .mem_we       (mem_we),
      .mem_addr_w   (mem_addr_w),
      .mem_addr_r   (mem_addr_r),
      .mem_din      (mem_din),
      .mem_dout     (mem_dout)
`ifdef FIFO_BRAM_CTRL_ERR_EN
      ,
      .overflow     (overflow),
      .underflow    (underflow)
`endif
   );

   // Simple dual-port RAM, registered read, read-before-write on address collision.
   logic [DW-1:0] ram [4];
   always_ff @(posedge clk) begin
      if (mem_we) ram[mem_addr_w] <= mem_din;
      mem_dout <= ram[mem_addr_r];
   end

   typedef struct {
      logic          wr;
      logic [DW-1:0] wd;
      logic          rd;
      logic          rst;
      logic          cc;     // check combinational RAM drive before the edge
      logic          we;
      logic [AW-1:0] aw;
      logic [AW-1:0] ar;
      logic [AW:0]   cnt;
      logic          emp;
      logic          ful;
      logic          af;
      logic          ae;
      logic          rv;
      logic [DW-1:0] rdat;
      logic          ovf;
      logic          unf;
   } vec_t;

   vec_t vecs [16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic w, input logic [DW-1:0] d, input logic r, input logic rs);
      wr = w; w_data = d; rd = r; reset = rs;
      @(negedge clk);
   endtask

   task automatic edge_settle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      //          wr   wd     rd   rst  cc   we   aw ar cnt emp ful af ae rv rdat   ovf unf
      vecs[0]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0, 1, 0, 0, 1, 0, 8'h00, 0, 0};
      vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0, 1, 0, 0, 1, 0, 8'h00, 0, 0};
      vecs[2]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 1, 0, 0, 0, 1, 0, 8'h00, 0, 0};
      vecs[3]  = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 1'b1, 1, 0, 2, 0, 0, 0, 0, 0, 8'h00, 0, 0};
      vecs[4]  = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 1'b1, 2, 0, 3, 0, 0, 1, 0, 0, 8'h00, 0, 0};
      vecs[5]  = '{1'b1, 8'h44, 1'b0, 1'b0, 1'b1, 1'b1, 3, 0, 4, 0, 1, 1, 0, 0, 8'h00, 0, 0};
      vecs[6]  = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 4, 0, 1, 1, 0, 0, 8'h00, 1, 0};
      vecs[7]  = '{1'b1, 8'h55, 1'b1, 1'b0, 1'b1, 1'b1, 0, 0, 4, 0, 1, 1, 0, 1, 8'h11, 1, 0};
      vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1, 1, 3, 0, 0, 1, 0, 1, 8'h22, 1, 0};
      vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1, 2, 2, 0, 0, 0, 0, 1, 8'h33, 1, 0};
      vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1, 3, 1, 0, 0, 0, 1, 1, 8'h44, 1, 0};
      vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1, 0, 0, 1, 0, 0, 1, 1, 8'h55, 1, 0};
      vecs[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1, 1, 0, 1, 0, 0, 1, 0, 8'h00, 1, 1};
      vecs[13] = '{1'b1, 8'hAA, 1'b0, 1'b0, 1'b1, 1'b1, 1, 1, 1, 0, 0, 0, 1, 0, 8'h00, 1, 1};
      vecs[14] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 2, 1, 0, 1, 0, 0, 1, 0, 8'h00, 0, 0};
      vecs[15] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0, 1, 0, 0, 1, 0, 8'h00, 0, 0};

      for (int i = 0; i < 16; i++) begin
         drive(vecs[i].wr, vecs[i].wd, vecs[i].rd, vecs[i].rst);
         if (vecs[i].cc) begin
            chk($sformatf("v%0d mem_we", i), 32'(mem_we), 32'(vecs[i].we));
            chk($sformatf("v%0d mem_addr_w", i), 32'(mem_addr_w), 32'(vecs[i].aw));
            chk($sformatf("v%0d mem_addr_r", i), 32'(mem_addr_r), 32'(vecs[i].ar));
            if (vecs[i].we) chk($sformatf("v%0d mem_din", i), 32'(mem_din), 32'(vecs[i].wd));
         end
         edge_settle();
         chk($sformatf("v%0d count", i), 32'(count), 32'(vecs[i].cnt));
         chk($sformatf("v%0d empty", i), 32'(empty), 32'(vecs[i].emp));
         chk($sformatf("v%0d full", i), 32'(full), 32'(vecs[i].ful));
         chk($sformatf("v%0d almost_full", i), 32'(almost_full), 32'(vecs[i].af));
         chk($sformatf("v%0d almost_empty", i), 32'(almost_empty), 32'(vecs[i].ae));
         chk($sformatf("v%0d r_valid", i), 32'(r_valid), 32'(vecs[i].rv));
         if (vecs[i].rv) chk($sformatf("v%0d r_data", i), 32'(r_data), 32'(vecs[i].rdat));
`ifdef FIFO_BRAM_CTRL_ERR_EN
         chk($sformatf("v%0d overflow", i), 32'(overflow), 32'(vecs[i].ovf));
         chk($sformatf("v%0d underflow", i), 32'(underflow), 32'(vecs[i].unf));
`endif
      end

      // Empty with wr & rd together: only the write is taken, no bypass.
      drive(1'b1, 8'h5A, 1'b1, 1'b0);
      chk("empty_wr_rd mem_we", 32'(mem_we), 32'd1);
      edge_settle();
      chk("empty_wr_rd count", 32'(count), 32'd1);
      chk("empty_wr_rd r_valid", 32'(r_valid), 32'd0);
      // Pop right after the push: data returns one cycle later.
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      edge_settle();
      chk("wr_to_rd r_valid", 32'(r_valid), 32'd1);
      chk("wr_to_rd r_data", 32'(r_data), 32'h5A);
      chk("wr_to_rd empty", 32'(empty), 32'd1);

      // Mid-level simultaneous push/pop keeps count steady.
      drive(1'b1, 8'h01, 1'b0, 1'b0);
      edge_settle();
      drive(1'b1, 8'h02, 1'b0, 1'b0);
      edge_settle();
      drive(1'b1, 8'h03, 1'b1, 1'b0);
      edge_settle();
      chk("mid_wr_rd count", 32'(count), 32'd2);
      chk("mid_wr_rd r_valid", 32'(r_valid), 32'd1);
      chk("mid_wr_rd r_data", 32'(r_data), 32'h01);
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      edge_settle();
      chk("mid_pop2 r_data", 32'(r_data), 32'h02);
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      edge_settle();
      chk("mid_pop3 r_data", 32'(r_data), 32'h03);
      chk("mid_pop3 empty", 32'(empty), 32'd1);
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      edge_settle();
      chk("idle r_valid", 32'(r_valid), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
